// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Arbitrates the single port of the instruction memory between CPU fetch and
//   a byte-serial program loader. While idle the CPU reads the memory
//   combinationally. During a load the CPU is stalled and sees HALT_OP. Byte
//   pairs (high byte first) are packed into words and written from address 0
//   upward. On completion or abort the CPU is told to restart at PC 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   load_start/len      start a load of len words (0 = 2**ADDR_W), IDLE only
//   load_abort          cancel a load in progress
//   byte_valid/data     loader byte stream, byte_ready is the accept strobe
//   busy                any state other than IDLE
//   load_done           one-cycle pulse after the last word is written
//   load_err            sticky, set by an abort, cleared by load_start or rst
//   cpu_addr/instr      CPU fetch path, cpu_stall holds the CPU
//   cpu_restart         one-cycle pulse, CPU reloads PC = 0
//   mem_addr/we/wdata   memory port, mem_rdata is async read data at mem_addr
module imem_load_ctrl #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] HALT_OP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    // One extra bit so a full-depth load (len = 2**ADDR_W) is representable
    // and the final write lands on the top address without wrapping.
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] len;
    logic [7:0]      hi_byte;
    logic [7:0]      lo_byte;

    // Abort only has effect while bytes are being gathered or written.
    logic aborting;
    assign aborting = load_abort && (state == GET_HI || state == GET_LO || state == WRITE);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            len      <= '0;
            hi_byte  <= '0;
            lo_byte  <= '0;
            load_err <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        count    <= '0;
                        load_err <= 1'b0;
                        len      <= (load_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                     : {1'b0, load_len};
                    end
                end
                GET_HI: if (!load_abort && byte_valid) hi_byte <= byte_data;
                GET_LO: if (!load_abort && byte_valid) lo_byte <= byte_data;
                WRITE:  if (!load_abort) count <= count + 1'b1;
                default: ;
            endcase
            if (aborting) load_err <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        byte_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = count[ADDR_W-1:0];
        mem_wdata   = {hi_byte, lo_byte};
        cpu_instr   = HALT_OP;
        cpu_stall   = 1'b1;
        load_done   = 1'b0;
        cpu_restart = 1'b0;

        case (state)
            IDLE: begin
                mem_addr  = cpu_addr;
                cpu_instr = mem_rdata;
                cpu_stall = 1'b0;
                if (load_start) state_next = GET_HI;
            end
            GET_HI: begin
                // Abort wins over a same-cycle byte: do not accept it.
                byte_ready = !load_abort;
                if (load_abort)      state_next = IDLE;
                else if (byte_valid) state_next = GET_LO;
            end
            GET_LO: begin
                byte_ready = !load_abort;
                if (load_abort)      state_next = IDLE;
                else if (byte_valid) state_next = WRITE;
            end
            WRITE: begin
                if (load_abort) begin
                    state_next = IDLE;
                end else begin
                    mem_we     = 1'b1;
                    state_next = ((count + 1'b1) == len) ? DONE : GET_HI;
                end
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        cpu_restart = (state == DONE) || aborting;

        // A reset in the middle of a load must not let the pending write or
        // pulses escape on the reset edge.
        if (rst) begin
            mem_we      = 1'b0;
            load_done   = 1'b0;
            cpu_restart = 1'b0;
            byte_ready  = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  load_len = '0;
    logic        load_abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, busy, load_done, load_err;
    logic [7:0]  cpu_addr = 8'd5;
    logic [15:0] cpu_instr;
    logic        cpu_stall, cpu_restart;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // Memory model and event counters
    logic [15:0] mem [0:255];
    int wr_cnt = 0, zero_wr_cnt = 0, done_cnt = 0, restart_cnt = 0;
    logic [7:0] last_addr = '0;

    logic [7:0] src [0:511];
    int src_idx = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_addr     <= mem_addr;
            if (mem_addr == 8'h00) zero_wr_cnt <= zero_wr_cnt + 1;
        end
        if (load_done)   done_cnt    <= done_cnt + 1;
        if (cpu_restart) restart_cnt <= restart_cnt + 1;
    end

    imem_load_ctrl #(.ADDR_W(8), .DATA_W(16), .HALT_OP(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_len(load_len), .load_abort(load_abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .busy(busy), .load_done(load_done), .load_err(load_err),
        .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
        .cpu_restart(cpu_restart),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start cycle is cycle 1; load_start is dropped by feed on cycle 2.
    task automatic start_load(input logic [7:0] len);
        @(posedge clk); #1;
        load_start = 1'b1;
        load_len   = len;
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    // Streams src[] bytes; returns the cycle number of load_done or of the
    // abort cycle, 0 if neither was seen within max_cycles.
    task automatic feed(input int max_cycles, input bit gap, input int abort_at,
                        output int end_cyc);
        end_cyc = 0;
        for (int c = 2; c <= max_cycles + 1; c++) begin
            @(posedge clk); #1;
            load_start = 1'b0;
            byte_valid = gap ? (c % 2 == 0) : 1'b1;
            byte_data  = src[src_idx];
            if (abort_at >= 0 && wr_cnt == abort_at) load_abort = 1'b1;
            @(negedge clk);
            if (byte_valid && byte_ready && !load_abort) src_idx++;
            if (load_done || load_abort) begin
                end_cyc = c;
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        load_abort = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int d;
        int wr0, z0, dn0, rs0;

        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        mem[5] = 16'h5005;

        // 1. Reset and idle fetch
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cpu_instr", cpu_instr, 16'h5005);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 8'd5);
        check("rst_busy", busy, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_flags", {load_done, load_err, cpu_restart}, 0);

        // 2. Two-word load, bytes every cycle
        src[0] = 8'h50; src[1] = 8'h05; src[2] = 8'h51; src[3] = 8'h0A; src[4] = 8'hEE;
        src_idx = 0; wr0 = wr_cnt; dn0 = done_cnt; rs0 = restart_cnt;
        start_load(8'd2);
        check("t2_busy_start_cycle", busy, 0);
        feed(40, 1'b0, -1, d);
        check("t2_done_cycle", d, 8);
        check("t2_busy_cycle9", busy, 0);
        check("t2_stall_cycle9", cpu_stall, 0);
        check("t2_mem0", mem[0], 16'h5005);
        check("t2_mem1", mem[1], 16'h510A);
        check("t2_writes", wr_cnt - wr0, 2);
        check("t2_done_pulses", done_cnt - dn0, 1);
        check("t2_restart_pulses", restart_cnt - rs0, 1);

        // 3. Backpressure, len=1
        src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hCC; src[3] = 8'hDD;
        src_idx = 0; wr0 = wr_cnt;
        start_load(8'd1);
        feed(40, 1'b1, -1, d);
        check("t3_done_seen", d != 0, 1);
        check("t3_writes", wr_cnt - wr0, 1);
        check("t3_mem0", mem[0], 16'hA1B2);
        check("t3_bytes_consumed", src_idx, 2);

        // 4. Length 0 = 256 words
        for (int i = 0; i < 256; i++) begin
            src[2*i]   = 8'(i);
            src[2*i+1] = ~8'(i);
        end
        src_idx = 0; wr0 = wr_cnt; z0 = zero_wr_cnt; dn0 = done_cnt;
        start_load(8'd0);
        feed(1000, 1'b0, -1, d);
        check("t4_done_cycle", d, 770);
        check("t4_writes", wr_cnt - wr0, 256);
        check("t4_last_addr", last_addr, 8'hFF);
        check("t4_addr0_writes", zero_wr_cnt - z0, 1);
        check("t4_done_pulses", done_cnt - dn0, 1);
        check("t4_mem0", mem[0], 16'h00FF);
        check("t4_mem128", mem[128], 16'h807F);
        check("t4_mem255", mem[255], 16'hFF00);

        // 5. Abort after 3 words
        for (int i = 0; i < 8; i++) src[i] = 8'h10 + 8'(i);
        src_idx = 0; wr0 = wr_cnt; dn0 = done_cnt; rs0 = restart_cnt;
        start_load(8'd5);
        feed(60, 1'b0, wr_cnt + 3, d);
        check("t5_abort_seen", d != 0, 1);
        check("t5_writes", wr_cnt - wr0, 3);
        check("t5_load_err", load_err, 1);
        check("t5_busy", busy, 0);
        check("t5_restart_pulses", restart_cnt - rs0, 1);
        check("t5_no_done", done_cnt - dn0, 0);
        check("t5_mem2", mem[2], 16'h1415);
        src[0] = 8'h77; src[1] = 8'h88; src_idx = 0;
        start_load(8'd1);
        check("t5_err_held_start", load_err, 1);
        @(posedge clk); #1; load_start = 1'b0; @(negedge clk);
        check("t5_err_cleared", load_err, 0);
        feed(20, 1'b0, -1, d);
        check("t5_reload_mem0", mem[0], 16'h7788);

        // 6. load_start while busy ignored; rst during GET_LO
        wr0 = wr_cnt; dn0 = done_cnt;
        start_load(8'd4);
        @(posedge clk); #1; load_start = 1'b0; byte_valid = 1'b1; byte_data = 8'h11;
        @(negedge clk);
        check("t6_ready_hi", byte_ready, 1);
        @(posedge clk); #1; load_start = 1'b1; load_len = 8'd1; byte_data = 8'h22;
        @(negedge clk);
        check("t6_ready_lo", byte_ready, 1);
        @(posedge clk); #1; load_start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        check("t6_write_we", mem_we, 1);
        check("t6_write_data", mem_wdata, 16'h1122);
        check("t6_write_addr", mem_addr, 8'h00);
        @(posedge clk); #1; byte_valid = 1'b1; byte_data = 8'h33;
        @(negedge clk);
        check("t6_len_not_resampled", {busy, load_done, byte_ready}, 3'b101);
        @(posedge clk); #1; byte_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6_stall_in_lo", cpu_stall, 1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_outputs", {byte_ready, load_done, load_err, cpu_restart, mem_we, cpu_stall}, 0);
        check("t6_rst_fetch", cpu_instr, 16'h05FA);
        check("t6_writes", wr_cnt - wr0, 1);
        check("t6_no_done", done_cnt - dn0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
